// File: rtl/mips_shift_pipe.sv
// Pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// A register slot follows every STAGES_PER_REG shift stages; the last slot drives the outputs.
module mips_shift_pipe #(
  parameter int WIDTH          = 32,
  parameter int STAGES_PER_REG = 2,
  parameter int TAG_W          = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           shift_in,
  input  logic [$clog2(WIDTH)-1:0]   shift_amount,
  input  logic [1:0]                 shift_op,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           shift_out,
  output logic [TAG_W-1:0]           tag_out
);

  localparam int unsigned N   = $clog2(WIDTH);
  localparam int unsigned SPR = STAGES_PER_REG;
  localparam int unsigned L   = (N + SPR - 1) / SPR;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Applies shift stages lo..hi-1 (stage k moves by 2^k when amt[k] is set).
  function automatic logic [WIDTH-1:0] shift_stages(
    input logic [WIDTH-1:0] d,
    input logic [N-1:0]     amt,
    input logic [1:0]       op,
    input logic             sgn,
    input int unsigned      lo,
    input int unsigned      hi
  );
    logic [WIDTH-1:0] r;
    int unsigned      s;
    r = d;
    for (int unsigned k = 0; k < N; k++) begin
      if (k >= lo && k < hi && amt[k]) begin
        s = 1 << k;
        case (op_e'(op))
          OP_SLL:  r = r << s;
          OP_SRL:  r = r >> s;
          OP_SRA:  r = (r >> s) | ({WIDTH{sgn}} << (WIDTH - s));
          default: r = (r >> s) | (r << (WIDTH - s));
        endcase
      end
    end
    return r;
  endfunction

  logic [L-1:0] vld;
  logic [L-1:0] ld;
  logic         ld_down;

  // Load enables ripple back from out_ready so an empty slot fills even while downstream stalls.
  always_comb begin
    ld      = '0;
    ld_down = out_ready;
    for (int unsigned j = 0; j < L; j++) begin
      ld[L-1-j] = !vld[L-1-j] || ld_down;
      ld_down   = ld[L-1-j];
    end
  end

  assign in_ready = ld[0];

  for (genvar i = 0; i < L; i++) begin : g_slot
    localparam int unsigned LO = i * SPR;
    localparam int unsigned HI = ((i + 1) * SPR > N) ? N : (i + 1) * SPR;

    logic             vin;
    logic [WIDTH-1:0] din;
    logic [N-1:0]     ain;
    logic [1:0]       opin;
    logic             sgnin;
    logic [TAG_W-1:0] tagin;

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;

    if (i == 0) begin : g_src
      assign vin   = in_valid;
      assign din   = shift_in;
      assign ain   = shift_amount;
      assign opin  = shift_op;
      assign sgnin = shift_in[WIDTH-1];
      assign tagin = tag_in;
    end else begin : g_src
      assign vin   = g_slot[i-1].vld_q;
      assign din   = g_slot[i-1].data_q;
      assign ain   = g_slot[i-1].g_meta.amt_q;
      assign opin  = g_slot[i-1].g_meta.op_q;
      assign sgnin = g_slot[i-1].g_meta.sgn_q;
      assign tagin = g_slot[i-1].tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        tag_q  <= '0;
      end else if (ld[i]) begin
        vld_q <= vin;
        if (vin) begin
          data_q <= shift_stages(din, ain, opin, sgnin, LO, HI);
          tag_q  <= tagin;
        end
      end
    end

    // Op, amount and captured sign only travel to slots that still have stages to apply.
    if (i < L - 1) begin : g_meta
      logic [N-1:0] amt_q;
      logic [1:0]   op_q;
      logic         sgn_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          amt_q <= '0;
          op_q  <= '0;
          sgn_q <= 1'b0;
        end else if (ld[i] && vin) begin
          amt_q <= ain;
          op_q  <= opin;
          sgn_q <= sgnin;
        end
      end
    end

    assign vld[i] = vld_q;
  end

  assign out_valid = g_slot[L-1].vld_q;
  assign shift_out = g_slot[L-1].data_q;
  assign tag_out   = g_slot[L-1].tag_q;

endmodule

// File: tb/tb_mips_shift_pipe.sv
// Randomised and directed bench for mips_shift_pipe: WIDTH=32/SPR=2, WIDTH=8/SPR=1, WIDTH=64/SPR=6,
// each scored against a bit-level reference shifter through per-instance expectation queues.
module tb_mips_shift_pipe;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0, in_ready, out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] shift_in = '0, shift_out;
  logic [4:0]  shift_amount = '0, tag_in = '0, tag_out;
  logic [1:0]  shift_op = '0;
  // 8-bit instance
  logic        v8 = 1'b0, r8, ov8;
  logic        or8 = 1'b1;
  logic [7:0]  si8 = '0, so8;
  logic [2:0]  sa8 = '0;
  logic [1:0]  op8 = '0;
  logic [4:0]  tg8 = '0, to8;
  // 64-bit instance
  logic        v64 = 1'b0, r64, ov64;
  logic        or64 = 1'b1;
  logic [63:0] si64 = '0, so64;
  logic [5:0]  sa64 = '0;
  logic [1:0]  op64 = '0;
  logic [4:0]  tg64 = '0, to64;

  mips_shift_pipe #(.WIDTH(32), .STAGES_PER_REG(2), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .shift_in(shift_in), .shift_amount(shift_amount), .shift_op(shift_op), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .shift_out(shift_out), .tag_out(tag_out)
  );
  mips_shift_pipe #(.WIDTH(8), .STAGES_PER_REG(1), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .shift_in(si8), .shift_amount(sa8), .shift_op(op8), .tag_in(tg8),
    .out_valid(ov8), .out_ready(or8), .shift_out(so8), .tag_out(to8)
  );
  mips_shift_pipe #(.WIDTH(64), .STAGES_PER_REG(6), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
    .shift_in(si64), .shift_amount(sa64), .shift_op(op64), .tag_in(tg64),
    .out_valid(ov64), .out_ready(or64), .shift_out(so64), .tag_out(to64)
  );

  int   checks = 0;
  int   failures = 0;
  int   outcnt = 0;
  exp_t q[3][$];
  logic ready_mode = 1'b0;
  logic ready_val  = 1'b1;

  // Reference: each result bit defined directly from the operand bit it must come from.
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input int w, input int a,
                                            input logic [1:0] op);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      case (op)
        2'd0:    r[j] = (j >= a) ? x[j-a] : 1'b0;
        2'd1:    r[j] = (j + a < w) ? x[j+a] : 1'b0;
        2'd2:    r[j] = (j + a < w) ? x[j+a] : x[w-1];
        default: r[j] = x[(j+a)%w];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic score(input int id, input logic ov, input logic ordy,
                       input logic [63:0] so, input logic [4:0] to);
    if (!ov) return;
    if (q[id].size() == 0) begin
      checks++;
      failures++;
      $display("FAIL dup%0d out_valid with no pending beat actual=%h required=none", id, so);
      return;
    end
    chk($sformatf("data%0d", id), so, q[id][0].d);
    chk($sformatf("tag%0d", id), 64'(to), 64'(q[id][0].t));
    if (ordy) begin
      void'(q[id].pop_front());
      if (id == 0) outcnt++;
    end
  endtask

  // Single compare process: outputs sampled mid-cycle, input handshakes recorded for the next edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out32", {out_valid, tag_out, shift_out}, '0);
      chk("rst_out8", {ov8, to8, so8}, '0);
      chk("rst_out64", {ov64, to64}, '0);
      chk("rst_data64", so64, '0);
      chk("rst_in_ready", {in_ready, r8, r64}, 3'b111);
      for (int unsigned k = 0; k < 3; k++) q[k].delete();
    end else begin
      score(0, out_valid, out_ready, 64'(shift_out), tag_out);
      score(1, ov8, or8, 64'(so8), to8);
      score(2, ov64, or64, so64, to64);
      if (in_valid && in_ready)
        q[0].push_back('{ref_shift(64'(shift_in), 32, int'(shift_amount), shift_op), tag_in});
      if (v8 && r8)
        q[1].push_back('{ref_shift(64'(si8), 8, int'(sa8), op8), tg8});
      if (v64 && r64)
        q[2].push_back('{ref_shift(si64, 64, int'(sa64), op64), tg64});
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input logic [4:0] t, output int waits);
    shift_in = d; shift_amount = a; shift_op = op; tag_in = t; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain32();
    int n;
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    n = 0;
    while ((q[0].size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain32", 64'(q[0].size()), 64'd0);
  endtask

  task automatic run_one(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                         input logic [31:0] expv, input string nm);
    int w, lat;
    send32(d, a, op, 5'(a ^ 5'h15), w);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk(nm, 64'(shift_out), 64'(expv));
    @(posedge clk); #1;
  endtask

  logic [31:0] sd[5];
  logic [4:0]  sa[5];
  logic [1:0]  so[5];

  initial begin
    int w, wsum, acc, c0, n;
    logic got;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_one(32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, "sll31");
    run_one(32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, "srl31");
    run_one(32'h8000_00F0, 5'd4,  2'd2, 32'hF800_000F, "sra4");
    run_one(32'h0000_00A5, 5'd4,  2'd3, 32'h5000_000A, "ror4");
    run_one(32'h7FFF_FFFF, 5'd31, 2'd2, 32'h0000_0000, "sra31_pos");
    run_one(32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF, "sra_amt0");
    drain32();

    ready_mode = 1'b1;
    for (int unsigned k = 0; k < 16; k++)
      send32($urandom, 5'($urandom), 2'($urandom), 5'($urandom), w);
    drain32();

    c0 = outcnt;
    wsum = 0;
    for (int unsigned k = 0; k < 16; k++) begin
      send32($urandom, 5'($urandom), 2'($urandom), 5'($urandom), w);
      wsum += w;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("tput_stalls", 64'(wsum), 64'd0);
    chk("tput_outs", 64'(outcnt - c0), 64'd16);
    drain32();

    for (int unsigned k = 0; k < 5; k++) begin
      sd[k] = $urandom; sa[k] = 5'($urandom); so[k] = 2'($urandom);
    end
    ready_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    acc = 0;
    shift_in = sd[0]; shift_amount = sa[0]; shift_op = so[0]; tag_in = 5'd0; in_valid = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) begin
        acc++;
        if (acc < 5) begin
          shift_in = sd[acc]; shift_amount = sa[acc]; shift_op = so[acc]; tag_in = 5'(acc);
        end
      end
    end
    @(negedge clk);
    chk("stall_accepts", 64'(acc), 64'd3);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    ready_val = 1'b1;
    send32(sd[3], sa[3], so[3], 5'd3, w);
    send32(sd[4], sa[4], so[4], 5'd4, w);
    drain32();

    ready_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int unsigned k = 0; k < 3; k++)
      send32($urandom, 5'($urandom), 2'($urandom), 5'($urandom), w);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {out_valid, tag_out, shift_out}, '0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_val = 1'b1;
    @(posedge clk); #1;
    run_one(32'h1234_5678, 5'd8, 2'd3, 32'h7812_3456, "post_rst_ror8");
    drain32();

    for (int unsigned op = 0; op < 4; op++) begin
      for (int unsigned a = 0; a < 8; a++) begin
        si8 = 8'($urandom); si8[7] = a[0] ^ op[0];
        sa8 = 3'(a); op8 = 2'(op); tg8 = 5'($urandom); v8 = 1'b1;
        @(negedge clk);
        n = 0;
        while (!r8 && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
      end
    end
    v8 = 1'b0;
    for (int unsigned op = 0; op < 4; op++) begin
      for (int unsigned a = 0; a < 64; a++) begin
        si64 = {$urandom, $urandom}; si64[63] = a[0] ^ op[0];
        sa64 = 6'(a); op64 = 2'(op); tg64 = 5'($urandom); v64 = 1'b1;
        @(negedge clk);
        n = 0;
        while (!r64 && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
      end
    end
    v64 = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("drain8", 64'(q[1].size()), 64'd0);
    chk("drain64", 64'(q[2].size()), 64'd0);
    chk("drain32_final", 64'(q[0].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
